reorder_buffer: RTL and testbench



---
 rtl/ooo_pkg.sv | 21 ++
 rtl/rob_retire_select.sv | 31 +++
 rtl/reorder_buffer.sv | 129 ++++++++++++
 tb/tb_reorder_buffer.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ooo_pkg.sv
// Shared types and constants for the out-of-order core's reorder buffer slice.
package ooo_pkg;

  localparam int unsigned DATA_W     = 16;
  localparam int unsigned REG_W      = 4;
  localparam int unsigned ROB_DEPTH  = 16;
  localparam int unsigned RETIRE_W   = 3;
  localparam int unsigned COMPLETE_W = 2;
  localparam int unsigned ROB_TAG_W  = $clog2(ROB_DEPTH);

  typedef logic [ROB_TAG_W-1:0] rob_tag_t;

  typedef struct packed {
    logic              valid;
    logic              done;
    logic              writes_reg;
    logic [REG_W-1:0]  dest;
    logic [DATA_W-1:0] value;
  } rob_entry_t;

endpackage

// File: rtl/rob_retire_select.sv
// Picks the contiguous run of valid+done entries starting at head, capped at the
// retire width; the first not-ready entry blocks everything younger.
module rob_retire_select import ooo_pkg::*; #(
  parameter int unsigned DEPTH = ROB_DEPTH,
  parameter int unsigned SEL_W = RETIRE_W
) (
  input  logic [$clog2(DEPTH)-1:0]   head,
  input  logic [DEPTH-1:0]           valid,
  input  logic [DEPTH-1:0]           done,
  output logic [$clog2(SEL_W+1)-1:0] retire_cnt,
  output logic [$clog2(DEPTH)-1:0]   retire_idx [0:SEL_W-1]
);

  localparam int unsigned TAG_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(SEL_W + 1);

  logic blocked;

  always_comb begin
    retire_cnt = '0;
    blocked    = 1'b0;
    for (int unsigned j = 0; j < SEL_W; j++) begin
      retire_idx[j] = head + TAG_W'(j);
      if (!blocked && valid[retire_idx[j]] && done[retire_idx[j]])
        retire_cnt = retire_cnt + CNT_W'(1);
      else
        blocked = 1'b1;
    end
  end

endmodule

// File: rtl/reorder_buffer.sv
// In-order retirement queue: one dispatch per cycle, two writeback ports, up to
// three registered retirements per cycle. Optional flush port under ROB_FLUSH_EN.
module reorder_buffer import ooo_pkg::*; #(
  parameter int unsigned DEPTH  = ooo_pkg::ROB_DEPTH,
  parameter int unsigned DATA_W = ooo_pkg::DATA_W,
  parameter int unsigned REG_W  = ooo_pkg::REG_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
`ifdef ROB_FLUSH_EN
  input  logic                     flush,
`endif
  input  logic                     alloc_valid,
  input  logic [REG_W-1:0]         alloc_dest,
  input  logic                     alloc_writes_reg,
  output logic                     alloc_ready,
  output logic [$clog2(DEPTH)-1:0] alloc_tag,
  input  logic                     complete_valid [0:COMPLETE_W-1],
  input  logic [$clog2(DEPTH)-1:0] complete_tag   [0:COMPLETE_W-1],
  input  logic [DATA_W-1:0]        complete_value [0:COMPLETE_W-1],
  output logic                     retirement_write_data_enable [0:RETIRE_W-1],
  output logic [DATA_W-1:0]        retirement_write_data        [0:RETIRE_W-1],
  output logic [REG_W-1:0]         retirement_target_reg        [0:RETIRE_W-1],
  output logic                     empty
);

  localparam int unsigned TAG_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = TAG_W + 1;
  localparam int unsigned SEL_W = $clog2(RETIRE_W + 1);

  logic [TAG_W-1:0]  head_q, tail_q;
  logic [CNT_W-1:0]  count_q;
  logic [DEPTH-1:0]  valid_q, done_q;
  logic [DEPTH-1:0]  wr_q;
  logic [REG_W-1:0]  dest_q  [DEPTH];
  logic [DATA_W-1:0] value_q [DEPTH];

  logic              flush_i;
  logic              alloc_fire;
  logic [SEL_W-1:0]  retire_cnt;
  logic [TAG_W-1:0]  retire_idx [0:RETIRE_W-1];
  logic [RETIRE_W-1:0] ret_mask;

`ifdef ROB_FLUSH_EN
  assign flush_i = flush;
`else
  assign flush_i = 1'b0;
`endif

  assign alloc_ready = (count_q != CNT_W'(DEPTH));
  assign alloc_tag   = tail_q;
  assign empty       = (count_q == '0);
  assign alloc_fire  = alloc_valid && alloc_ready;

  rob_retire_select #(
    .DEPTH (DEPTH),
    .SEL_W (RETIRE_W)
  ) u_retire_select (
    .head       (head_q),
    .valid      (valid_q),
    .done       (done_q),
    .retire_cnt (retire_cnt),
    .retire_idx (retire_idx)
  );

  always_comb begin
    ret_mask = '0;
    for (int unsigned j = 0; j < RETIRE_W; j++)
      ret_mask[j] = (32'(retire_cnt) > j);
  end

  // Later assignments win: port 1 over port 0, retirement over completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
      done_q  <= '0;
      for (int unsigned j = 0; j < RETIRE_W; j++) begin
        retirement_write_data_enable[j] <= 1'b0;
        retirement_write_data[j]        <= '0;
        retirement_target_reg[j]        <= '0;
      end
    end else if (flush_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
      done_q  <= '0;
      for (int unsigned j = 0; j < RETIRE_W; j++)
        retirement_write_data_enable[j] <= 1'b0;
    end else begin
      for (int unsigned p = 0; p < COMPLETE_W; p++)
        if (complete_valid[p] && valid_q[complete_tag[p]])
          done_q[complete_tag[p]] <= 1'b1;
      for (int unsigned j = 0; j < RETIRE_W; j++) begin
        retirement_write_data_enable[j] <= ret_mask[j] && wr_q[retire_idx[j]];
        if (ret_mask[j] && wr_q[retire_idx[j]]) begin
          retirement_write_data[j] <= value_q[retire_idx[j]];
          retirement_target_reg[j] <= dest_q[retire_idx[j]];
        end
        if (ret_mask[j]) begin
          valid_q[retire_idx[j]] <= 1'b0;
          done_q[retire_idx[j]]  <= 1'b0;
        end
      end
      if (alloc_fire) begin
        valid_q[tail_q] <= 1'b1;
        done_q[tail_q]  <= 1'b0;
        tail_q          <= tail_q + TAG_W'(1);
      end
      head_q  <= head_q + TAG_W'(retire_cnt);
      count_q <= count_q + CNT_W'(alloc_fire) - CNT_W'(retire_cnt);
    end
  end

  // Payload needs no reset: it is only read behind a set valid bit.
  always_ff @(posedge clk) begin
    for (int unsigned p = 0; p < COMPLETE_W; p++)
      if (complete_valid[p] && valid_q[complete_tag[p]])
        value_q[complete_tag[p]] <= complete_value[p];
    if (alloc_fire) begin
      dest_q[tail_q] <= alloc_dest;
      wr_q[tail_q]   <= alloc_writes_reg;
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed self-checking bench for reorder_buffer; drives and samples on negedge.
module tb_reorder_buffer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        alloc_valid;
  logic [3:0]  alloc_dest;
  logic        alloc_writes_reg;
  logic        alloc_ready;
  logic [3:0]  alloc_tag;
  logic        complete_valid [0:1];
  logic [3:0]  complete_tag   [0:1];
  logic [15:0] complete_value [0:1];
  logic        en   [0:2];
  logic [15:0] data [0:2];
  logic [3:0]  tgt  [0:2];
  logic        empty;
`ifdef ROB_FLUSH_EN
  logic        flush = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  logic [15:0] rf [16];

  always #5 clk = ~clk;

  reorder_buffer #(.DEPTH(16), .DATA_W(16), .REG_W(4)) dut (
    .clk                          (clk),
    .rst_n                        (rst_n),
`ifdef ROB_FLUSH_EN
    .flush                        (flush),
`endif
    .alloc_valid                  (alloc_valid),
    .alloc_dest                   (alloc_dest),
    .alloc_writes_reg             (alloc_writes_reg),
    .alloc_ready                  (alloc_ready),
    .alloc_tag                    (alloc_tag),
    .complete_valid               (complete_valid),
    .complete_tag                 (complete_tag),
    .complete_value               (complete_value),
    .retirement_write_data_enable (en),
    .retirement_write_data        (data),
    .retirement_target_reg        (tgt),
    .empty                        (empty)
  );

  task automatic step();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    alloc_valid = 1'b0;
    alloc_dest = '0;
    alloc_writes_reg = 1'b0;
    for (int p = 0; p < 2; p++) begin
      complete_valid[p] = 1'b0;
      complete_tag[p]   = '0;
      complete_value[p] = '0;
    end
  endtask

  task automatic alloc_one(input logic [3:0] d, input logic w);
    alloc_valid = 1'b1;
    alloc_dest = d;
    alloc_writes_reg = w;
    step();
    alloc_valid = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %0b want 1", empty); end
    checks++; if (alloc_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b want 1", alloc_ready); end
    checks++; if (alloc_tag !== 4'd0) begin errors++; $display("FAIL reset_tag got %0d want 0", alloc_tag); end
    checks++; if ({en[0], en[1], en[2]} !== 3'b000) begin errors++; $display("FAIL reset_en got %b want 000", {en[0], en[1], en[2]}); end
    checks++; if ({data[0], data[1], data[2]} !== 48'h0) begin errors++; $display("FAIL reset_data got %h want 0", {data[0], data[1], data[2]}); end
  endtask

  task automatic test_in_order();
    for (int i = 0; i < 3; i++) begin
      checks++; if (alloc_tag !== 4'(i)) begin errors++; $display("FAIL inorder_tag got %0d want %0d", alloc_tag, i); end
      alloc_one(4'(i + 1), 1'b1);
    end
    complete_valid[0] = 1'b1; complete_tag[0] = 4'd1; complete_value[0] = 16'h2222;
    complete_valid[1] = 1'b1; complete_tag[1] = 4'd2; complete_value[1] = 16'h3333;
    step();
    complete_valid[1] = 1'b0;
    complete_tag[0] = 4'd0; complete_value[0] = 16'h1111;
    step();
    clear_inputs();
    step();
    checks++; if ({en[0], en[1], en[2]} !== 3'b111) begin errors++; $display("FAIL inorder_en got %b want 111", {en[0], en[1], en[2]}); end
    checks++; if ({tgt[0], tgt[1], tgt[2]} !== 12'h123) begin errors++; $display("FAIL inorder_tgt got %h want 123", {tgt[0], tgt[1], tgt[2]}); end
    checks++; if ({data[0], data[1], data[2]} !== 48'h1111_2222_3333) begin errors++; $display("FAIL inorder_data got %h want 111122223333", {data[0], data[1], data[2]}); end
    step();
    checks++; if ({en[0], en[1], en[2]} !== 3'b000) begin errors++; $display("FAIL inorder_pulse got %b want 000", {en[0], en[1], en[2]}); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL inorder_empty got %0b want 1", empty); end
  endtask

  task automatic test_blocking();
    alloc_one(4'd4, 1'b1);
    alloc_one(4'd5, 1'b1);
    alloc_one(4'd6, 1'b1);
    complete_valid[0] = 1'b1; complete_tag[0] = 4'd4; complete_value[0] = 16'h4444;
    complete_valid[1] = 1'b1; complete_tag[1] = 4'd5; complete_value[1] = 16'h5555;
    step();
    clear_inputs();
    step();
    step();
    checks++; if ({en[0], en[1], en[2]} !== 3'b000) begin errors++; $display("FAIL block_en got %b want 000", {en[0], en[1], en[2]}); end
    checks++; if (empty !== 1'b0) begin errors++; $display("FAIL block_empty got %0b want 0", empty); end
    complete_valid[0] = 1'b1; complete_tag[0] = 4'd3; complete_value[0] = 16'hAAAA;
    step();
    clear_inputs();
    step();
    checks++; if ({en[0], en[1], en[2]} !== 3'b111) begin errors++; $display("FAIL block_en3 got %b want 111", {en[0], en[1], en[2]}); end
    checks++; if ({tgt[0], tgt[1], tgt[2]} !== 12'h456) begin errors++; $display("FAIL block_tgt got %h want 456", {tgt[0], tgt[1], tgt[2]}); end
    checks++; if ({data[0], data[1], data[2]} !== 48'hAAAA_4444_5555) begin errors++; $display("FAIL block_data got %h want aaaa44445555", {data[0], data[1], data[2]}); end
  endtask

  task automatic test_full();
    for (int i = 0; i < 16; i++) alloc_one(4'(i), 1'b1);
    checks++; if (alloc_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %0b want 0", alloc_ready); end
    alloc_valid = 1'b1; alloc_dest = 4'hF; alloc_writes_reg = 1'b1;
    step();
    alloc_valid = 1'b0;
    checks++; if (alloc_tag !== 4'd0) begin errors++; $display("FAIL full_tag got %0d want 0", alloc_tag); end
    checks++; if (alloc_ready !== 1'b0) begin errors++; $display("FAIL full_ready2 got %0b want 0", alloc_ready); end
    complete_valid[0] = 1'b1; complete_tag[0] = 4'd0; complete_value[0] = 16'h0F0F;
    step();
    clear_inputs();
    step();
    checks++; if ({en[0], en[1], en[2]} !== 3'b100) begin errors++; $display("FAIL full_en got %b want 100", {en[0], en[1], en[2]}); end
    checks++; if (tgt[0] !== 4'd0 || data[0] !== 16'h0F0F) begin errors++; $display("FAIL full_slot0 got %h/%h want 0/0f0f", tgt[0], data[0]); end
    checks++; if (alloc_ready !== 1'b1) begin errors++; $display("FAIL full_ready3 got %0b want 1", alloc_ready); end
    checks++; if (alloc_tag !== 4'd0) begin errors++; $display("FAIL full_tag2 got %0d want 0", alloc_tag); end
  endtask

  task automatic test_wrap_same_dest();
    for (int i = 0; i < 16; i++) begin
      alloc_valid = (i < 15); alloc_dest = '0; alloc_writes_reg = 1'b0;
      complete_valid[0] = (i > 0); complete_tag[0] = 4'(i - 1); complete_value[0] = '0;
      step();
    end
    clear_inputs();
    step(); step(); step();
    checks++; if (empty !== 1'b1 || alloc_tag !== 4'd15) begin errors++; $display("FAIL wrap_prime got empty=%0b tag=%0d want 1/15", empty, alloc_tag); end
    alloc_one(4'd5, 1'b1);
    checks++; if (alloc_tag !== 4'd0) begin errors++; $display("FAIL wrap_tag got %0d want 0", alloc_tag); end
    alloc_one(4'd5, 1'b1);
    alloc_one(4'd5, 1'b1);
    complete_valid[0] = 1'b1; complete_tag[0] = 4'd0; complete_value[0] = 16'h00B0;
    complete_valid[1] = 1'b1; complete_tag[1] = 4'd1; complete_value[1] = 16'h00B1;
    step();
    complete_valid[1] = 1'b0;
    complete_tag[0] = 4'd15; complete_value[0] = 16'h00BF;
    step();
    clear_inputs();
    step();
    checks++; if ({en[0], en[1], en[2]} !== 3'b111) begin errors++; $display("FAIL wrap_en got %b want 111", {en[0], en[1], en[2]}); end
    checks++; if ({tgt[0], tgt[1], tgt[2]} !== 12'h555) begin errors++; $display("FAIL wrap_tgt got %h want 555", {tgt[0], tgt[1], tgt[2]}); end
    checks++; if ({data[0], data[1], data[2]} !== 48'h00BF_00B0_00B1) begin errors++; $display("FAIL wrap_data got %h want 00bf00b000b1", {data[0], data[1], data[2]}); end
    rf[5] = '0;
    for (int j = 0; j < 3; j++) if (en[j]) rf[tgt[j]] = data[j];
    checks++; if (rf[5] !== 16'h00B1) begin errors++; $display("FAIL wrap_rf got %h want 00b1", rf[5]); end
  endtask

  task automatic test_port_conflict();
    checks++; if (alloc_tag !== 4'd2) begin errors++; $display("FAIL conf_tag got %0d want 2", alloc_tag); end
    alloc_one(4'd6, 1'b1);
    alloc_one(4'd8, 1'b0);
    alloc_one(4'd7, 1'b1);
    complete_valid[0] = 1'b1; complete_tag[0] = 4'd4; complete_value[0] = 16'h0009;
    step();
    complete_valid[1] = 1'b1; complete_tag[1] = 4'd4; complete_value[0] = 16'h0001; complete_value[1] = 16'h0002;
    step();
    complete_tag[0] = 4'd2; complete_value[0] = 16'h0022;
    complete_tag[1] = 4'd3; complete_value[1] = 16'h0033;
    step();
    clear_inputs();
    step();
    checks++; if ({en[0], en[1], en[2]} !== 3'b101) begin errors++; $display("FAIL conf_en got %b want 101", {en[0], en[1], en[2]}); end
    checks++; if (data[2] !== 16'h0002 || tgt[2] !== 4'd7) begin errors++; $display("FAIL conf_slot2 got %h/%h want 0002/7", data[2], tgt[2]); end
    checks++; if (data[0] !== 16'h0022 || tgt[0] !== 4'd6) begin errors++; $display("FAIL conf_slot0 got %h/%h want 0022/6", data[0], tgt[0]); end
    checks++; if (data[1] !== 16'h00B0 || tgt[1] !== 4'd5) begin errors++; $display("FAIL conf_hold got %h/%h want 00b0/5", data[1], tgt[1]); end
  endtask

  task automatic test_invalid_complete();
    complete_valid[0] = 1'b1; complete_tag[0] = 4'd5; complete_value[0] = 16'hDEAD;
    step();
    clear_inputs();
    alloc_one(4'd9, 1'b1);
    step(); step();
    checks++; if ({en[0], en[1], en[2]} !== 3'b000 || empty !== 1'b0) begin errors++; $display("FAIL inval_en got %b empty=%0b want 000/0", {en[0], en[1], en[2]}, empty); end
    complete_valid[0] = 1'b1; complete_tag[0] = 4'd5; complete_value[0] = 16'h0505;
    step();
    clear_inputs();
    step();
    checks++; if ({en[0], en[1], en[2]} !== 3'b100 || data[0] !== 16'h0505 || tgt[0] !== 4'd9) begin errors++; $display("FAIL inval_retire got %b %h %h want 100 0505 9", {en[0], en[1], en[2]}, data[0], tgt[0]); end
  endtask

  task automatic test_reset_midstream();
    for (int i = 0; i < 5; i++) alloc_one(4'(i + 1), 1'b1);
    complete_valid[0] = 1'b1; complete_tag[0] = 4'd6; complete_value[0] = 16'h6666;
    complete_valid[1] = 1'b1; complete_tag[1] = 4'd7; complete_value[1] = 16'h7777;
    step();
    clear_inputs();
    rst_n = 1'b0;
    #1;
    checks++; if ({en[0], en[1], en[2]} !== 3'b000 || empty !== 1'b1) begin errors++; $display("FAIL mid_rst got %b empty=%0b want 000/1", {en[0], en[1], en[2]}, empty); end
    checks++; if (alloc_tag !== 4'd0 || alloc_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_tag got %0d ready=%0b want 0/1", alloc_tag, alloc_ready); end
    step();
    rst_n = 1'b1;
    step(); step();
    checks++; if ({en[0], en[1], en[2]} !== 3'b000 || empty !== 1'b1 || alloc_tag !== 4'd0) begin errors++; $display("FAIL mid_post got %b empty=%0b tag=%0d want 000/1/0", {en[0], en[1], en[2]}, empty, alloc_tag); end
  endtask

  initial begin
    clear_inputs();
    step(); step();
    rst_n = 1'b1;
    step();
    test_reset();
    test_in_order();
    test_blocking();
    do_reset();
    test_full();
    do_reset();
    test_wrap_same_dest();
    test_port_conflict();
    test_invalid_complete();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
